// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding and load-use stall control (optional counters: FWD_HAZARD_STATS_EN)
`ifndef OP_ADD
`define OP_ADD  6'd1
`define OP_SUB  6'd2
`define OP_ADDI 6'd3
`define OP_SUBI 6'd4
`define OP_LW   6'd5
`define OP_SW   6'd6
`endif

module fwd_hazard_unit #(
  parameter int REG_W      = 5,
  parameter int PIPE_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op_code,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [1:0]       Forward_A,
  output logic [1:0]       Forward_B,
  output logic [1:0]       Forward_C
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      fwd_events
`endif
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hz;
  logic [CNT_W-1:0] need;

  // slot 0 is EX; slots 1..PIPE_DEPTH are the post-EX stages
  logic [PIPE_DEPTH:0] s_valid, s_rw, s_load;
  logic [REG_W-1:0]    s_rd [0:PIPE_DEPTH];
  logic [5:0]          ex_op;
  logic [REG_W-1:0]    ex_rs, ex_rt;

  function automatic logic uses_a(input logic [5:0] op);
    return (op == `OP_ADD) || (op == `OP_SUB) || (op == `OP_ADDI) ||
           (op == `OP_SUBI) || (op == `OP_LW) || (op == `OP_SW);
  endfunction

  function automatic logic uses_b(input logic [5:0] op);
    return (op == `OP_ADD) || (op == `OP_SUB);
  endfunction

  function automatic logic uses_c(input logic [5:0] op);
    return (op == `OP_SW);
  endfunction

  // load-use detection for the ID instruction; the youngest matching load sets the stall length
  always_comb begin
    hz   = 1'b0;
    need = '0;
    for (int j = LOAD_LAT - 1; j >= 0; j--) begin
      if (s_valid[j] && s_load[j] && (s_rd[j] != '0) &&
          ((uses_a(id_op_code) && (id_rs == s_rd[j])) ||
           ((uses_b(id_op_code) || uses_c(id_op_code)) && (id_rt == s_rd[j])))) begin
        hz   = 1'b1;
        need = CNT_W'(LOAD_LAT - j);
      end
    end
    if (!id_valid) begin
      hz = 1'b0;
    end
  end

  // stall FSM next state; flush wins over both hazard and an ongoing stall
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    if (flush) begin
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            stall = 1'b1;
            if (need > CNT_W'(1)) begin
              state_n = STALL;
              cnt_n   = need - CNT_W'(1);
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // stall FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // scoreboard shift; slot 0 takes a bubble on stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= '0;
      s_rw    <= '0;
      s_load  <= '0;
      for (int k = 0; k <= PIPE_DEPTH; k++) begin
        s_rd[k] <= '0;
      end
      ex_op <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
    end else begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        s_valid[k] <= s_valid[k-1];
        s_rw[k]    <= s_rw[k-1];
        s_load[k]  <= s_load[k-1];
        s_rd[k]    <= s_rd[k-1];
      end
      s_valid[0] <= id_valid && !stall && !flush;
      s_rw[0]    <= id_reg_write;
      s_load[0]  <= (id_op_code == `OP_LW);
      s_rd[0]    <= id_rd;
      ex_op      <= id_op_code;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
    end
  end

  // forward selects: scan oldest to youngest so the youngest producer overwrites
  always_comb begin
    Forward_A = 2'b00;
    Forward_B = 2'b00;
    Forward_C = 2'b00;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (s_valid[0] && s_valid[k] && s_rw[k] && (s_rd[k] != '0)) begin
        if (uses_a(ex_op) && (ex_rs == s_rd[k])) Forward_A = 2'(k);
        if (uses_b(ex_op) && (ex_rt == s_rd[k])) Forward_B = 2'(k);
        if (uses_c(ex_op) && (ex_rt == s_rd[k])) Forward_C = 2'(k);
      end
    end
  end

  assign ex_valid = s_valid[0];

`ifdef FWD_HAZARD_STATS_EN
  // saturating activity counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (((Forward_A | Forward_B | Forward_C) != 2'b00) && (fwd_events != 16'hFFFF)) begin
        fwd_events <= fwd_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit
`ifndef OP_ADD
`define OP_ADD  6'd1
`define OP_SUB  6'd2
`define OP_ADDI 6'd3
`define OP_SUBI 6'd4
`define OP_LW   6'd5
`define OP_SW   6'd6
`endif

module tb_fwd_hazard_unit;
  localparam int RW = 5;
  localparam int PD = 3;
  localparam int LL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [5:0]    id_op_code = '0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          id_reg_write = 1'b0;
  logic          flush = 1'b0;
  logic          stall, ex_valid;
  logic [1:0]    Forward_A, Forward_B, Forward_C;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0]   stall_cycles, fwd_events;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_W(RW), .PIPE_DEPTH(PD), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_code(id_op_code),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .Forward_A(Forward_A), .Forward_B(Forward_B), .Forward_C(Forward_C)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
  );

  typedef struct {
    logic          v;
    logic [5:0]    op;
    logic [RW-1:0] rs, rt, rd;
    logic          w;
  } ins_t;

  typedef struct {
    logic       st;
    logic       ev;
    logic [1:0] a, b, c;
  } exp_t;

  ins_t hist[$];   // hist[0] = instruction in EX, hist[k] = k stages past EX
  exp_t sbq[$];
  int   checks = 0, failures = 0;
  int   rem = 0;
  int   stall_total = 0, fwd_total = 0;
  bit   last_st = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit use_a(input logic [5:0] op);
    return op inside {`OP_ADD, `OP_SUB, `OP_ADDI, `OP_SUBI, `OP_LW, `OP_SW};
  endfunction
  function automatic bit use_b(input logic [5:0] op);
    return op inside {`OP_ADD, `OP_SUB};
  endfunction
  function automatic bit use_c(input logic [5:0] op);
    return op == `OP_SW;
  endfunction

  // most recent in-flight writer of s, by distance from EX
  function automatic logic [1:0] producer(input logic [RW-1:0] s);
    for (int k = 1; k <= PD; k++)
      if (s != 0 && hist[k].v && hist[k].w && hist[k].rd == s) return 2'(k);
    return 2'b00;
  endfunction

  // cycles the ID instruction must wait for load data, 0 if none
  function automatic int load_wait();
    for (int j = 0; j < LL; j++)
      if (id_valid && hist[j].v && hist[j].op == `OP_LW && hist[j].rd != 0 &&
          ((use_a(id_op_code) && id_rs == hist[j].rd) ||
           ((use_b(id_op_code) || use_c(id_op_code)) && id_rt == hist[j].rd)))
        return LL - j;
    return 0;
  endfunction

  task automatic model_reset();
    ins_t nb;
    nb.v = 0; nb.op = 0; nb.rs = 0; nb.rt = 0; nb.rd = 0; nb.w = 0;
    hist.delete();
    for (int i = 0; i <= PD; i++) hist.push_back(nb);
    rem = 0; stall_total = 0; fwd_total = 0; last_st = 0;
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [RW-1:0] rs,
                      input logic [RW-1:0] rt, input logic [RW-1:0] rd, input logic w,
                      input logic fl);
    exp_t e;
    ins_t ni;
    int   need;
    @(posedge clk); #1;
    id_valid = v; id_op_code = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = w; flush = fl;
    need = load_wait();
    e.st = !fl && (rem > 0 || need > 0);
    e.ev = hist[0].v;
    e.a  = (hist[0].v && use_a(hist[0].op)) ? producer(hist[0].rs) : 2'b00;
    e.b  = (hist[0].v && use_b(hist[0].op)) ? producer(hist[0].rt) : 2'b00;
    e.c  = (hist[0].v && use_c(hist[0].op)) ? producer(hist[0].rt) : 2'b00;
    sbq.push_back(e);
    if (e.st) stall_total++;
    if ((e.a | e.b | e.c) != 0) fwd_total++;
    last_st = e.st;
    ni.v = v && !e.st && !fl; ni.op = op; ni.rs = rs; ni.rt = rt; ni.rd = rd; ni.w = w;
    hist.push_front(ni);
    void'(hist.pop_back());
    if (fl) rem = 0;
    else if (rem > 0) rem--;
    else if (need > 1) rem = need - 1;
    else rem = 0;
  endtask

  task automatic nop();
    step(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_stall"}, {15'd0, stall}, 16'd0);
    chk({tag, "_ex_valid"}, {15'd0, ex_valid}, 16'd0);
    chk({tag, "_fwd_a"}, {14'd0, Forward_A}, 16'd0);
    chk({tag, "_fwd_b"}, {14'd0, Forward_B}, 16'd0);
    chk({tag, "_fwd_c"}, {14'd0, Forward_C}, 16'd0);
  endtask

  // monitor: compare every DUT cycle that has a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", {15'd0, stall}, {15'd0, e.st});
        chk("ex_valid", {15'd0, ex_valid}, {15'd0, e.ev});
        chk("forward_a", {14'd0, Forward_A}, {14'd0, e.a});
        chk("forward_b", {14'd0, Forward_B}, {14'd0, e.b});
        chk("forward_c", {14'd0, Forward_C}, {14'd0, e.c});
      end
    end
  end

  initial begin
    logic [5:0]    ops [8];
    logic [5:0]    c_op;
    logic [RW-1:0] c_rs, c_rt, c_rd;
    logic          c_v, c_w;
    ops = '{`OP_ADD, `OP_SUB, `OP_ADDI, `OP_SUBI, `OP_LW, `OP_SW, 6'd0, 6'h3F};
    c_op = 0; c_rs = 0; c_rt = 0; c_rd = 0; c_v = 0; c_w = 0;

    #1;
    check_quiet("reset");
    #2 rst = 1'b0;
    model_reset();

    // back-to-back ALU dependency
    step(1, `OP_ADD, 5'd1, 5'd2, 5'd3, 1, 0);
    step(1, `OP_SUB, 5'd3, 5'd1, 5'd4, 1, 0);
    nop(); nop();

    // youngest producer wins for store base and data
    step(1, `OP_ADD, 5'd1, 5'd2, 5'd3, 1, 0);
    nop();
    step(1, `OP_ADDI, 5'd1, 5'd0, 5'd3, 1, 0);
    step(1, `OP_SW, 5'd3, 5'd3, 5'd0, 0, 0);
    nop();

    // r0 destination never forwards
    step(1, `OP_ADD, 5'd1, 5'd2, 5'd0, 1, 0);
    step(1, `OP_SUB, 5'd0, 5'd0, 5'd4, 1, 0);
    nop(); nop();

    // load one slot away: single stall cycle
    step(1, `OP_LW, 5'd1, 5'd0, 5'd5, 1, 0);
    nop();
    repeat (2) step(1, `OP_ADD, 5'd5, 5'd5, 5'd6, 1, 0);
    nop(); nop(); nop();

    // load immediately ahead: two stall cycles, store data from oldest slot
    step(1, `OP_LW, 5'd1, 5'd0, 5'd7, 1, 0);
    repeat (3) step(1, `OP_SW, 5'd2, 5'd7, 5'd0, 0, 0);
    nop(); nop(); nop(); nop();

    // flush on the first stall cycle
    step(1, `OP_LW, 5'd1, 5'd0, 5'd5, 1, 0);
    step(1, `OP_ADD, 5'd5, 5'd5, 5'd6, 1, 1);
    nop(); nop(); nop();

    // asynchronous reset while in STALL
    step(1, `OP_LW, 5'd1, 5'd0, 5'd7, 1, 0);
    step(1, `OP_SW, 5'd2, 5'd7, 5'd0, 0, 0);
    @(posedge clk); #1;
    id_valid = 0; flush = 0;
    rst = 1'b1;
    #1;
    check_quiet("reset_mid_stall");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // randomized traffic; ID is held while a stall is expected
    for (int i = 0; i < 600; i++) begin
      if (!last_st) begin
        c_op = ops[$urandom_range(0, 7)];
        c_rs = RW'($urandom_range(0, 3));
        c_rt = RW'($urandom_range(0, 3));
        c_rd = RW'($urandom_range(0, 3));
        c_v  = ($urandom_range(0, 7) != 0);
        c_w  = (c_op != `OP_SW) && ($urandom_range(0, 7) != 0);
      end
      step(c_v, c_op, c_rs, c_rt, c_rd, c_w, ($urandom_range(0, 19) == 0));
    end
    step(0, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0);

`ifdef FWD_HAZARD_STATS_EN
    @(posedge clk); #1;
    chk("stall_cycles", stall_cycles, 16'(stall_total));
    chk("fwd_events", fwd_events, 16'(fwd_total));
`endif

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
